// File: rtl/trap_sequencer.sv
// Trap sequencer: steps through reset hold, normal operation, trap entry and trap
// return, and drives the PC select, flush and CSR update strobes for each phase.
module trap_sequencer #(
    parameter int RESET_HOLD_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       stall_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out
);

    typedef enum logic [1:0] {
        RESET       = 2'b00,
        OPERATING   = 2'b01,
        TRAP_TAKEN  = 2'b10,
        TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] holdCnt_q, holdCnt_d;
    logic [3:0] causeCode_q, causeCode_d;
    logic       isInterrupt_q, isInterrupt_d;

    logic excEvent;
    logic irqEvent;

    assign excEvent = misaligned_instr_in | illegal_instr_in | ebreak_in | ecall_in
                    | misaligned_load_in | misaligned_store_in;
    assign irqEvent = mie_in & ((meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= RESET;
            holdCnt_q     <= 4'd0;
            causeCode_q   <= 4'd0;
            isInterrupt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdCnt_q     <= holdCnt_d;
            causeCode_q   <= causeCode_d;
            isInterrupt_q <= isInterrupt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        holdCnt_d = 4'd0;
        case (state_q)
            RESET: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d = OPERATING;
                end else begin
                    holdCnt_d = holdCnt_q + 4'd1;
                end
            end
            OPERATING: begin
                if (!stall_in) begin
                    if (irqEvent || excEvent) begin
                        state_d = TRAP_TAKEN;
                    end else if (mret_in) begin
                        state_d = TRAP_RETURN;
                    end
                end
            end
            TRAP_TAKEN:  state_d = OPERATING;
            TRAP_RETURN: state_d = OPERATING;
            default:     state_d = RESET;
        endcase
    end

    // Cause is captured only on the edge that enters TRAP_TAKEN and held otherwise.
    always_comb begin
        causeCode_d   = causeCode_q;
        isInterrupt_d = isInterrupt_q;
        if (state_q == OPERATING && !stall_in) begin
            if (irqEvent) begin
                isInterrupt_d = 1'b1;
                if (meie_in && meip_in) begin
                    causeCode_d = 4'd11;
                end else if (msie_in && msip_in) begin
                    causeCode_d = 4'd3;
                end else begin
                    causeCode_d = 4'd7;
                end
            end else if (excEvent) begin
                isInterrupt_d = 1'b0;
                if (misaligned_instr_in) begin
                    causeCode_d = 4'd0;
                end else if (illegal_instr_in) begin
                    causeCode_d = 4'd2;
                end else if (ebreak_in) begin
                    causeCode_d = 4'd3;
                end else if (ecall_in) begin
                    causeCode_d = 4'd11;
                end else if (misaligned_load_in) begin
                    causeCode_d = 4'd4;
                end else begin
                    causeCode_d = 4'd6;
                end
            end
        end
    end

    // Strobes are decoded from state alone, except instret which also needs the live stall/event.
    always_comb begin
        pc_src_out      = 2'b00;
        flush_out       = 1'b0;
        trap_taken_out  = 1'b0;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        case (state_q)
            RESET: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
            OPERATING: begin
                pc_src_out      = 2'b11;
                instret_inc_out = ~stall_in & ~irqEvent & ~excEvent;
            end
            TRAP_TAKEN: begin
                pc_src_out     = 2'b10;
                flush_out      = 1'b1;
                trap_taken_out = 1'b1;
                set_cause_out  = 1'b1;
                set_epc_out    = 1'b1;
                mie_clear_out  = 1'b1;
            end
            TRAP_RETURN: begin
                pc_src_out  = 2'b01;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
            default: begin
                pc_src_out = 2'b00;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out  = causeCode_q;
    assign i_or_e_out = isInterrupt_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: reset hold, trap entry/return, cause
// priority, stall behaviour and asynchronous reset in the middle of a trap.
module tb_trap_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       illegalInstr, misalignedInstr, misalignedLoad, misalignedStore;
    logic       ecall, ebreak, mret;
    logic       mie, meie, mtie, msie, meip, mtip, msip;
    logic [1:0] pcSrc;
    logic       flush, trapTaken, setCause, setEpc, mieClear, mieSet, instretInc;
    logic [3:0] cause;
    logic       iOrE;

    int checks = 0;
    int errors = 0;

    trap_sequencer #(.RESET_HOLD_CYCLES(2)) dut (
        .clk_in              (clk),
        .reset_in            (reset),
        .stall_in            (stall),
        .illegal_instr_in    (illegalInstr),
        .misaligned_instr_in (misalignedInstr),
        .misaligned_load_in  (misalignedLoad),
        .misaligned_store_in (misalignedStore),
        .ecall_in            (ecall),
        .ebreak_in           (ebreak),
        .mret_in             (mret),
        .mie_in              (mie),
        .meie_in             (meie),
        .mtie_in             (mtie),
        .msie_in             (msie),
        .meip_in             (meip),
        .mtip_in             (mtip),
        .msip_in             (msip),
        .pc_src_out          (pcSrc),
        .flush_out           (flush),
        .trap_taken_out      (trapTaken),
        .set_cause_out       (setCause),
        .set_epc_out         (setEpc),
        .mie_clear_out       (mieClear),
        .mie_set_out         (mieSet),
        .instret_inc_out     (instretInc),
        .cause_out           (cause),
        .i_or_e_out          (iOrE)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus;
        stall = 0; illegalInstr = 0; misalignedInstr = 0; misalignedLoad = 0;
        misalignedStore = 0; ecall = 0; ebreak = 0; mret = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic checkTrapEntry(input string tag, input logic [3:0] expCause, input logic expIrq);
        checkOutput({tag, "_pc"}, 4'(pcSrc), 4'd2);
        checkOutput({tag, "_taken"}, 4'(trapTaken), 4'd1);
        checkOutput({tag, "_cause"}, cause, expCause);
        checkOutput({tag, "_ioe"}, 4'(iOrE), 4'(expIrq));
        checkOutput({tag, "_strobes"}, {setCause, setEpc, mieClear, flush}, 4'hF);
    endtask

    initial begin
        applyStimulus();
        reset = 1'b1;
        #12;
        checkOutput("rst_pc", 4'(pcSrc), 4'd0);
        checkOutput("rst_flush", 4'(flush), 4'd1);
        checkOutput("rst_others", {trapTaken, setCause, mieSet, instretInc}, 4'd0);
        checkOutput("rst_cause", cause, 4'd0);

        // Release reset: two RESET cycles, then OPERATING
        reset = 1'b0;
        #1;
        checkOutput("hold0_pc", 4'(pcSrc), 4'd0);
        stepCycle();
        checkOutput("hold1_pc", 4'(pcSrc), 4'd0);
        stepCycle();
        checkOutput("op_pc", 4'(pcSrc), 4'd3);
        checkOutput("op_instret", 4'(instretInc), 4'd1);
        checkOutput("op_flush", 4'(flush), 4'd0);

        // Illegal instruction
        illegalInstr = 1;
        #1;
        checkOutput("ill_instret", 4'(instretInc), 4'd0);
        stepCycle();
        applyStimulus();
        checkTrapEntry("ill", 4'd2, 1'b0);
        stepCycle();
        checkOutput("ill_back_pc", 4'(pcSrc), 4'd3);
        checkOutput("ill_back_taken", 4'(trapTaken), 4'd0);
        checkOutput("ill_cause_held", cause, 4'd2);

        // External interrupt beats ecall
        mie = 1; meie = 1; meip = 1; ecall = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("ext", 4'd11, 1'b1);
        stepCycle();

        // Software beats timer
        mie = 1; msie = 1; msip = 1; mtie = 1; mtip = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("sw", 4'd3, 1'b1);
        stepCycle();

        // Timer alone
        mie = 1; mtie = 1; mtip = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("tmr", 4'd7, 1'b1);
        stepCycle();

        // Global enable low masks the interrupt
        meie = 1; meip = 1;
        #1;
        checkOutput("masked_instret", 4'(instretInc), 4'd1);
        stepCycle();
        checkOutput("masked_pc", 4'(pcSrc), 4'd3);
        applyStimulus();

        // mret held off by stall, taken once stall drops
        mret = 1; stall = 1;
        #1;
        checkOutput("stall_instret", 4'(instretInc), 4'd0);
        stepCycle();
        checkOutput("mret_stall_pc1", 4'(pcSrc), 4'd3);
        stepCycle();
        checkOutput("mret_stall_pc2", 4'(pcSrc), 4'd3);
        stall = 0;
        stepCycle();
        mret = 0;
        checkOutput("mret_pc", 4'(pcSrc), 4'd1);
        checkOutput("mret_mieset", 4'(mieSet), 4'd1);
        checkOutput("mret_flush", 4'(flush), 4'd1);
        checkOutput("mret_cause_held", cause, 4'd7);
        stepCycle();
        checkOutput("mret_back_pc", 4'(pcSrc), 4'd3);

        // Event present as stall falls is not lost; stall in TRAP_TAKEN is ignored
        ecall = 1; stall = 1;
        stepCycle();
        checkOutput("ecall_stall_pc", 4'(pcSrc), 4'd3);
        stall = 0;
        stepCycle();
        checkTrapEntry("ecall", 4'd11, 1'b0);
        stall = 1;
        stepCycle();
        checkOutput("trap_ignores_stall", 4'(pcSrc), 4'd3);
        applyStimulus();

        // Exception priority cases
        misalignedLoad = 1; misalignedStore = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("ldst", 4'd4, 1'b0);
        stepCycle();
        misalignedStore = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("st", 4'd6, 1'b0);
        stepCycle();
        misalignedInstr = 1; illegalInstr = 1; ebreak = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("mis", 4'd0, 1'b0);
        stepCycle();
        ebreak = 1; ecall = 1;
        stepCycle();
        applyStimulus();
        checkTrapEntry("ebrk", 4'd3, 1'b0);

        // Asynchronous reset in the middle of TRAP_TAKEN
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_pc", 4'(pcSrc), 4'd0);
        checkOutput("async_flush", 4'(flush), 4'd1);
        checkOutput("async_others", {trapTaken, setCause, setEpc, mieClear}, 4'd0);
        checkOutput("async_cause", cause, 4'd0);
        checkOutput("async_ioe", 4'(iOrE), 4'd0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("rehold_pc", 4'(pcSrc), 4'd0);
        stepCycle();
        checkOutput("reop_pc", 4'(pcSrc), 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
